detect_scheduler: RTL and testbench

Shares one serial "110" pattern-detector datapath among NREQ requesters. Each requester offers a W-bit word. A round-robin arbiter grants one requester. The word is scanned MSB-first, one bit per clock, through the 110 FSM, and the block returns a per-bit match mask, a match count and the requester ID on a valid/ready result port. It sits between the word producers and the result consumer and owns all sequencing of the detector.

---
 rtl/detect_pkg.sv | 32 +++
 rtl/serial_110_core.sv | 38 +++
 rtl/detect_scheduler.sv | 139 +++++++++++++
 tb/tb_detect_scheduler.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/detect_pkg.sv
// detect_pkg: shared state encodings and the round-robin grant search
// used by detect_scheduler and serial_110_core.
package detect_pkg;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} sched_state_t;
  typedef enum logic [1:0] {D_S0, D_S1, D_S11} det_state_t;

  // The pick function works on a fixed-size view so it stays independent of
  // the scheduler parameters; requester counts up to MAX_REQ are supported.
  localparam int unsigned MAX_REQ = 32;
  localparam int unsigned PICK_W  = 5;

  // Index of the first set bit of valid[n-1:0] at or above ptr, with wrap.
  // Walks offsets from high to low so the smallest offset is the last to land.
  // Returns 0 when nothing is valid; callers qualify with |valid.
  function automatic logic [PICK_W-1:0] rr_pick(
    input logic [MAX_REQ-1:0] valid,
    input logic [PICK_W-1:0]  ptr,
    input logic [PICK_W:0]    n
  );
    logic [PICK_W:0]   idx;
    logic [PICK_W-1:0] sel;
    sel = '0;
    for (int i = MAX_REQ - 1; i >= 0; i--) begin
      idx = {1'b0, ptr} + (PICK_W + 1)'(i);
      if (idx >= n) idx = idx - n;
      if (((PICK_W + 1)'(i) < n) && valid[idx[PICK_W-1:0]]) sel = idx[PICK_W-1:0];
    end
    return sel;
  endfunction

endpackage

// File: rtl/serial_110_core.sv
// serial_110_core: bit-serial Mealy detector for the sequence 1,1,0.
// hit is combinational on the bit that completes the pattern.
module serial_110_core
  import detect_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic bit_en,
  input  logic bit_in,
  output logic hit
);

  det_state_t state_q, state_d;

  // Detector state register, async active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= D_S0;
    else        state_q <= state_d;
  end

  // Next state and Mealy hit; clr wins so each word starts from scratch.
  always_comb begin
    state_d = state_q;
    hit     = bit_en && (state_q == D_S11) && !bit_in;
    if (clr) begin
      state_d = D_S0;
    end else if (bit_en) begin
      case (state_q)
        D_S0:    state_d = bit_in ? D_S1  : D_S0;
        D_S1:    state_d = bit_in ? D_S11 : D_S0;
        D_S11:   state_d = bit_in ? D_S11 : D_S0;
        default: state_d = D_S0;
      endcase
    end
  end

endmodule

// File: rtl/detect_scheduler.sv
// detect_scheduler: arbitrates NREQ word producers onto one serial 110
// detector, scans the granted word MSB-first and returns mask/count/id.
// Build option FIXED_PRIO_EN: lowest-index valid requester always wins
// (no round-robin pointer); default build is round-robin.
module detect_scheduler
  import detect_pkg::*;
#(
  parameter  int NREQ = 4,
  parameter  int W    = 16,
  localparam int IDW  = $clog2(NREQ),
  localparam int CNTW = $clog2(W + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [IDW-1:0]    res_id,
  output logic [W-1:0]      res_mask,
  output logic [CNTW-1:0]   res_count,
  output logic              busy
);

  localparam int BW = $clog2(W);

  sched_state_t    state_q, state_d;
  logic [W-1:0]    shreg_q, shreg_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [BW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    mask_q, mask_d;
  logic [CNTW-1:0] count_q, count_d;
  logic [IDW-1:0]  grant_idx;
  logic            grant_any;
  logic            det_clr, det_en, det_hit;

`ifdef FIXED_PRIO_EN
  // Search always starts at requester 0.
  always_comb grant_idx = IDW'(rr_pick(MAX_REQ'(req_valid), '0, (PICK_W + 1)'(NREQ)));
`else
  logic [IDW-1:0] rr_q, rr_d;

  // Search starts at the round-robin pointer.
  always_comb grant_idx = IDW'(rr_pick(MAX_REQ'(req_valid), PICK_W'(rr_q), (PICK_W + 1)'(NREQ)));

  // Pointer moves past the owner of each delivered result.
  always_comb begin
    rr_d = rr_q;
    if (state_q == DONE && res_ready)
      rr_d = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + IDW'(1);
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rr_q <= '0;
    else        rr_q <= rr_d;
  end
`endif

  assign grant_any = |req_valid;

  serial_110_core u_core (
    .clk    (clk),
    .reset  (reset),
    .clr    (det_clr),
    .bit_en (det_en),
    .bit_in (shreg_q[W-1]),
    .hit    (det_hit)
  );

  // Sequencing: grant/latch in IDLE, one bit per cycle in SCAN, hold in DONE.
  // req_ready is also gated by reset so nothing is offered while held in reset.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    id_d      = id_q;
    cnt_d     = cnt_q;
    mask_d    = mask_q;
    count_d   = count_q;
    req_ready = '0;
    det_clr   = 1'b0;
    det_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_any && reset) begin
          req_ready[grant_idx] = 1'b1;
          shreg_d = req_data[grant_idx*W +: W];
          id_d    = grant_idx;
          cnt_d   = BW'(W - 1);
          mask_d  = '0;
          count_d = '0;
          det_clr = 1'b1;
          state_d = SCAN;
        end
      end
      SCAN: begin
        det_en  = 1'b1;
        shreg_d = {shreg_q[W-2:0], 1'b0};
        if (det_hit) begin
          mask_d[cnt_q] = 1'b1;
          count_d       = count_q + CNTW'(1);
        end
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - BW'(1);
      end
      DONE: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath and FSM registers; reset drops any scan in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      id_q    <= '0;
      cnt_q   <= '0;
      mask_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      count_q <= count_d;
    end
  end

  assign res_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign res_id    = id_q;
  assign res_mask  = mask_q;
  assign res_count = count_q;

endmodule

// File: tb/tb_detect_scheduler.sv
// tb_detect_scheduler: directed scenarios with hand-computed expectations.
module tb_detect_scheduler;

  localparam int NREQ = 4;
  localparam int W    = 16;
  localparam int IDW  = 2;
  localparam int CNTW = 5;

  logic              clk;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              res_valid;
  logic              res_ready;
  logic [IDW-1:0]    res_id;
  logic [W-1:0]      res_mask;
  logic [CNTW-1:0]   res_count;
  logic              busy;

  int n_asserts = 0;
  int n_fail    = 0;

  detect_scheduler #(.NREQ(NREQ), .W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_id    (res_id),
    .res_mask  (res_mask),
    .res_count (res_count),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Offer one word on requester r with res_ready high; returns result fields,
  // cycles waited for the grant, accept-to-res_valid latency and a timeout flag.
  // Called and returns at 1ns after a rising edge; the handshake edge is consumed.
  task automatic do_word(input int r, input logic [W-1:0] data,
                         output logic [IDW-1:0] id, output logic [W-1:0] mask,
                         output logic [CNTW-1:0] cnt, output int wt,
                         output int lat, output bit tmo);
    tmo = 0;
    req_valid = '0;
    req_valid[r] = 1'b1;
    req_data[r*W +: W] = data;
    res_ready = 1'b1;
    wt = 0;
    @(negedge clk);
    while (!req_ready[r] && wt < 100) begin @(negedge clk); wt++; end
    if (!req_ready[r]) tmo = 1;
    @(posedge clk); #1;
    req_valid[r] = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!res_valid && lat < 100);
    if (!res_valid) tmo = 1;
    id = res_id; mask = res_mask; cnt = res_count;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; req_valid = '0; req_data = '0; res_ready = 1'b0;
    repeat (2) @(negedge clk);
    req_valid = '1;
    @(negedge clk);
    n_asserts++;
    if ({req_ready, res_valid, res_id, res_mask, res_count, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: req_ready=%b res_valid=%b id=%0d mask=%h count=%0d busy=%b, required all 0",
               req_ready, res_valid, res_id, res_mask, res_count, busy);
    end
    @(posedge clk); #1;
    req_valid = '0; reset = 1'b1;
    @(negedge clk);
    n_asserts++;
    if (busy !== 1'b0 || req_ready !== '0) begin
      n_fail++;
      $display("FAIL reset_release_idle: busy=%b req_ready=%b, required 0/0", busy, req_ready);
    end
    $display("test_reset done");
  endtask

  task automatic test_patterns();
    logic [W-1:0] words [4] = '{16'hC000, 16'hEEEE, 16'h6DB6, 16'hFFFF};
    logic [W-1:0] masks [4] = '{16'h2000, 16'h1111, 16'h1249, 16'h0000};
    int           cnts  [4] = '{1, 4, 5, 0};
    logic [IDW-1:0] id; logic [W-1:0] mask; logic [CNTW-1:0] cnt;
    int wt, lat; bit tmo;
    for (int i = 0; i < 4; i++) begin
      do_word(i, words[i], id, mask, cnt, wt, lat, tmo);
      $display("word %h on req%0d -> id=%0d mask=%h count=%0d latency=%0d", words[i], i, id, mask, cnt, lat);
      n_asserts++;
      if (tmo !== 1'b0 || lat != W + 1) begin
        n_fail++;
        $display("FAIL pattern_latency[%0d]: timeout=%0d latency=%0d, required 0/%0d", i, tmo, lat, W + 1);
      end
      n_asserts++;
      if (id !== IDW'(i) || mask !== masks[i] || cnt !== CNTW'(cnts[i])) begin
        n_fail++;
        $display("FAIL pattern_result[%0d]: id=%0d mask=%h count=%0d, required %0d/%h/%0d",
                 i, id, mask, cnt, i, masks[i], cnts[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [IDW-1:0] id; logic [W-1:0] mask; logic [CNTW-1:0] cnt;
    int wt, lat; bit tmo;
    do_word(0, 16'h0003, id, mask, cnt, wt, lat, tmo);
    $display("word 0003 -> mask=%h count=%0d", mask, cnt);
    n_asserts++;
    if (tmo !== 1'b0 || mask !== 16'h0000 || cnt !== CNTW'(0)) begin
      n_fail++;
      $display("FAIL b2b_first: timeout=%0d mask=%h count=%0d, required 0/0000/0", tmo, mask, cnt);
    end
    do_word(0, 16'h0000, id, mask, cnt, wt, lat, tmo);
    $display("word 0000 -> mask=%h count=%0d grant_wait=%0d", mask, cnt, wt);
    n_asserts++;
    if (tmo !== 1'b0 || mask !== 16'h0000 || cnt !== CNTW'(0)) begin
      n_fail++;
      $display("FAIL b2b_no_carry: timeout=%0d mask=%h count=%0d, required 0/0000/0", tmo, mask, cnt);
    end
    n_asserts++;
    if (wt != 0) begin
      n_fail++;
      $display("FAIL b2b_spacing: grant wait=%0d cycles, required 0", wt);
    end
  endtask

  task automatic test_rr();
    logic [W-1:0] words [4] = '{16'hC000, 16'hEEEE, 16'h6DB6, 16'hFFFF};
    logic [W-1:0] masks [4] = '{16'h2000, 16'h1111, 16'h1249, 16'h0000};
`ifdef FIXED_PRIO_EN
    int exp_g [5] = '{0, 0, 0, 0, 0};
`else
    int exp_g [5] = '{0, 1, 2, 3, 0};
`endif
    logic [NREQ-1:0] exp_oh;
    int k, seen;
    @(posedge clk); #1; reset = 1'b0;
    @(posedge clk); #1; reset = 1'b1;
    for (int r = 0; r < NREQ; r++) req_data[r*W +: W] = words[r];
    req_valid = '1; res_ready = 1'b1;
    for (int g = 0; g < 5; g++) begin
      exp_oh = NREQ'(1) << exp_g[g];
      k = 0;
      @(negedge clk);
      while (req_ready == '0 && k < 100) begin @(negedge clk); k++; end
      $display("grant %0d: req_ready=%b", g, req_ready);
      n_asserts++;
      if (req_ready !== exp_oh) begin
        n_fail++;
        $display("FAIL rr_grant[%0d]: req_ready=%b, required %b", g, req_ready, exp_oh);
      end
      @(posedge clk); #1;
      seen = 0; k = 0;
      do begin @(negedge clk); if (req_ready != '0) seen++; k++; end while (!res_valid && k < 100);
      n_asserts++;
      if (res_valid !== 1'b1 || res_id !== IDW'(exp_g[g]) || seen != 0) begin
        n_fail++;
        $display("FAIL rr_result_id[%0d]: valid=%b id=%0d extra_ready=%0d, required 1/%0d/0",
                 g, res_valid, res_id, seen, exp_g[g]);
      end
      n_asserts++;
      if (res_mask !== masks[exp_g[g]]) begin
        n_fail++;
        $display("FAIL rr_result_mask[%0d]: mask=%h, required %h", g, res_mask, masks[exp_g[g]]);
      end
      @(posedge clk); #1;
    end
    req_valid = '0;
  endtask

  task automatic test_stall();
    logic [IDW-1:0] s_id; logic [W-1:0] s_mask; logic [CNTW-1:0] s_cnt;
    int k, bad;
    res_ready = 1'b0;
    req_valid = '0; req_valid[2] = 1'b1; req_data[2*W +: W] = 16'hEEEE;
    k = 0;
    @(negedge clk);
    while (!req_ready[2] && k < 100) begin @(negedge clk); k++; end
    @(posedge clk); #1;
    req_valid = 4'b0001; req_data[0 +: W] = 16'h6DB6;
    k = 0;
    @(negedge clk);
    while (!res_valid && k < 100) begin @(negedge clk); k++; end
    n_asserts++;
    if (res_valid !== 1'b1 || res_id !== 2'd2 || res_mask !== 16'h1111 || res_count !== 5'd4) begin
      n_fail++;
      $display("FAIL stall_result: valid=%b id=%0d mask=%h count=%0d, required 1/2/1111/4",
               res_valid, res_id, res_mask, res_count);
    end
    s_id = res_id; s_mask = res_mask; s_cnt = res_count;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      n_asserts++;
      if (res_valid !== 1'b1 || busy !== 1'b1 || req_ready !== '0 ||
          res_id !== s_id || res_mask !== s_mask || res_count !== s_cnt) begin
        n_fail++; bad++;
        $display("FAIL stall_hold[%0d]: valid=%b busy=%b req_ready=%b id=%0d mask=%h count=%0d, required 1/1/0000/%0d/%h/%0d",
                 c, res_valid, busy, req_ready, res_id, res_mask, res_count, s_id, s_mask, s_cnt);
      end
      @(negedge clk);
    end
    $display("stall: 10 held cycles, %0d bad", bad);
    @(posedge clk); #1; res_ready = 1'b1;
    @(negedge clk);
    n_asserts++;
    if (res_valid !== 1'b1 || req_ready !== '0) begin
      n_fail++;
      $display("FAIL stall_handshake_cycle: valid=%b req_ready=%b, required 1/0000", res_valid, req_ready);
    end
    @(posedge clk);
    @(negedge clk);
    n_asserts++;
    if (req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL stall_resume: req_ready=%b, required 0001", req_ready);
    end
    @(posedge clk); #1; req_valid = '0;
    k = 0;
    @(negedge clk);
    while (!res_valid && k < 100) begin @(negedge clk); k++; end
    $display("after stall: id=%0d mask=%h count=%0d", res_id, res_mask, res_count);
    n_asserts++;
    if (res_valid !== 1'b1 || res_id !== 2'd0 || res_mask !== 16'h1249 || res_count !== 5'd5) begin
      n_fail++;
      $display("FAIL stall_next_word: valid=%b id=%0d mask=%h count=%0d, required 1/0/1249/5",
               res_valid, res_id, res_mask, res_count);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midscan();
    int k;
    res_ready = 1'b1;
    req_valid = 4'b0010; req_data[1*W +: W] = 16'hEEEE;
    k = 0;
    @(negedge clk);
    while (!req_ready[1] && k < 100) begin @(negedge clk); k++; end
    @(posedge clk); #1;
    req_valid = '1;
    repeat (7) @(posedge clk);
    #2;
    n_asserts++;
    if (busy !== 1'b1 || res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midscan_busy: busy=%b valid=%b, required 1/0", busy, res_valid);
    end
    reset = 1'b0;
    #1;
    $display("reset mid-scan: req_ready=%b valid=%b id=%0d mask=%h count=%0d busy=%b",
             req_ready, res_valid, res_id, res_mask, res_count, busy);
    n_asserts++;
    if ({req_ready, res_valid, res_id, res_mask, res_count, busy} !== '0) begin
      n_fail++;
      $display("FAIL midscan_reset_outputs: req_ready=%b valid=%b id=%0d mask=%h count=%0d busy=%b, required all 0",
               req_ready, res_valid, res_id, res_mask, res_count, busy);
    end
    repeat (2) @(posedge clk);
    #1; reset = 1'b1;
    @(negedge clk);
    n_asserts++;
    if (req_ready !== 4'b0001 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midscan_first_grant: req_ready=%b busy=%b, required 0001/0", req_ready, busy);
    end
    @(posedge clk); #1; req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_patterns();
    test_back_to_back();
    test_rr();
    test_stall();
    test_reset_midscan();
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
